// File: rtl/arbiter_1_to_n_response_pkg.sv
// Shared packet/FIFO types and route helpers for the 1-to-N response arbiter.
package arbiter_1_to_n_response_pkg;

  localparam int unsigned ROUTE_ID_WIDTH = 8;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam logic [ROUTE_ID_WIDTH-1:0] RESPONSE_ROUTE_ID_MAX = '1;

  typedef enum logic [1:0] {
    CMD_INVALID,
    CMD_MEM_READ,
    CMD_MEM_WRITE,
    CMD_MEM_RESPONSE
  } CommandType;

  typedef struct packed {
    logic [ROUTE_ID_WIDTH-1:0] id_module;
  } RouteEndpoint;

  typedef struct packed {
    RouteEndpoint from;
    RouteEndpoint to;
  } PacketRoute;

  typedef struct packed {
    PacketRoute route;
    CommandType cmd;
  } PacketMeta;

  typedef struct packed {
    PacketMeta             meta;
    logic [DATA_WIDTH-1:0] data;
  } MemoryPacketPayload;

  typedef struct packed {
    logic               valid;
    MemoryPacketPayload payload;
  } MemoryPacket;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic full;
    logic empty;
    logic prog_full;
    logic wr_rst_busy;
    logic rd_rst_busy;
  } FIFOStateSignalsOutput;

  function automatic logic [ROUTE_ID_WIDTH-1:0] get_response_route_id(
    input MemoryPacketPayload payload
  );
    return payload.meta.route.from.id_module;
  endfunction

endpackage

// File: rtl/arbiter_1_to_n_response_decoder.sv
// Combinational route decode: one-hot FIFO select for routable responses,
// drop flag for anything valid that cannot be delivered.
module arbiter_1_to_n_response_decoder
  import arbiter_1_to_n_response_pkg::*;
#(
  parameter int unsigned NUM_MEMORY_REQUESTOR = 2,
  parameter int unsigned ID_WIDTH             = 1
) (
  input  logic                            valid_i,
  input  logic [ROUTE_ID_WIDTH-1:0]       route_id_i,
  input  CommandType                      cmd_i,
  input  logic [NUM_MEMORY_REQUESTOR-1:0] full_i,
  output logic [NUM_MEMORY_REQUESTOR-1:0] onehot_o,
  output logic                            drop_o
);
  logic [ID_WIDTH-1:0] idx;
  logic                routable;

  always_comb begin
    onehot_o = '0;
    drop_o   = 1'b0;
    idx      = route_id_i[ID_WIDTH-1:0];
    // Range check on the full id so aliased high ids are not silently routed.
    routable = ({{(32-ROUTE_ID_WIDTH){1'b0}}, route_id_i} < NUM_MEMORY_REQUESTOR);
    if (valid_i) begin
      if ((cmd_i == CMD_MEM_RESPONSE) && routable && !full_i[idx]) begin
        onehot_o[idx] = 1'b1;
      end else begin
        drop_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xpm_fifo_sync_wrapper.sv
// Synchronous FIFO, standard read mode with one-cycle read latency and
// reset-busy flags that stay high for a few cycles after reset.
module xpm_fifo_sync_wrapper #(
  parameter int unsigned FIFO_WRITE_DEPTH = 16,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned PROG_FULL_THRESH = 12,
  parameter int unsigned RST_BUSY_CYCLES  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  valid_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  empty_o,
  output logic                  prog_full_o,
  output logic                  wr_rst_busy_o,
  output logic                  rd_rst_busy_o
);
  localparam int unsigned AW = $clog2(FIFO_WRITE_DEPTH);
  localparam logic [AW:0]   CntOne = 1;
  localparam logic [AW-1:0] PtrOne = 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_WRITE_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic [3:0]            busy_cnt_q, busy_cnt_d;
  logic                  busy, do_wr, do_rd;

  always_comb begin
    busy          = rst_i | (busy_cnt_q != 4'd0);
    full_o        = (count_q == (AW+1)'(FIFO_WRITE_DEPTH));
    almost_full_o = (count_q == (AW+1)'(FIFO_WRITE_DEPTH - 1));
    empty_o       = (count_q == '0);
    prog_full_o   = (count_q >= (AW+1)'(PROG_FULL_THRESH));
    do_wr         = wr_en_i & ~full_o & ~busy;
    do_rd         = rd_en_i & ~empty_o & ~busy;
    wr_ptr_d      = do_wr ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d      = do_rd ? rd_ptr_q + PtrOne : rd_ptr_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    valid_d    = do_rd;
    dout_d     = do_rd ? mem_q[rd_ptr_q] : dout_q;
    busy_cnt_d = (busy_cnt_q != 4'd0) ? busy_cnt_q - 4'd1 : 4'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      busy_cnt_q <= 4'(RST_BUSY_CYCLES);
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    dout_q <= dout_d;
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o        = dout_q;
  assign valid_o       = valid_q;
  assign wr_rst_busy_o = busy;
  assign rd_rst_busy_o = busy;

endmodule

// File: rtl/arbiter_1_to_n_response.sv
// Routes the single memory-response stream into per-requestor FIFOs by
// route id, with aggregated backpressure and a saturating drop counter.
module arbiter_1_to_n_response
  import arbiter_1_to_n_response_pkg::*;
#(
  parameter int unsigned NUM_MEMORY_REQUESTOR = 2,
  parameter int unsigned ID_WIDTH = (NUM_MEMORY_REQUESTOR > 1) ? $clog2(NUM_MEMORY_REQUESTOR) : 1,
  parameter int unsigned FIFO_RESPONSE_DEPTH  = 16,
  parameter int unsigned PROG_THRESH          = 12
) (
  input  logic                                              ap_clk,
  input  logic                                              areset,
  input  MemoryPacket                                       response_in,
  input  FIFOStateSignalsInput [NUM_MEMORY_REQUESTOR-1:0]   fifo_response_signals_in,
  output FIFOStateSignalsOutput                             fifo_response_signals_out,
  output MemoryPacket [NUM_MEMORY_REQUESTOR-1:0]            response_out,
  output logic [NUM_MEMORY_REQUESTOR-1:0]                   response_ready_out,
  output logic [31:0]                                       drop_count,
  output logic                                              fifo_setup_signal
);
  localparam int unsigned PW = $bits(MemoryPacketPayload);

  logic                                 control_areset_q, fifo_areset_q;
  logic                                 s1_valid_q, s1_valid_d;
  MemoryPacketPayload                   s1_payload_q;
  logic [NUM_MEMORY_REQUESTOR-1:0]      rd_en_q, rd_en_d;
  logic [NUM_MEMORY_REQUESTOR-1:0]      s2_onehot_q, s2_onehot_d;
  MemoryPacketPayload                   s2_payload_q;
  logic [31:0]                          drop_count_q, drop_count_d;
  logic                                 setup_q, setup_d;
  logic [NUM_MEMORY_REQUESTOR-1:0]      ready_q, ready_d;
  FIFOStateSignalsOutput                status_q, status_d;
  logic [NUM_MEMORY_REQUESTOR-1:0]      out_valid_q, out_valid_d;
  MemoryPacketPayload [NUM_MEMORY_REQUESTOR-1:0] out_payload_q;

  logic [NUM_MEMORY_REQUESTOR-1:0] fifo_full, fifo_afull, fifo_empty, fifo_valid, fifo_pf;
  logic [NUM_MEMORY_REQUESTOR-1:0] fifo_wbusy, fifo_rbusy, fifo_rd_en, eff_full;
  logic [NUM_MEMORY_REQUESTOR-1:0][PW-1:0] fifo_dout;
  logic [NUM_MEMORY_REQUESTOR-1:0] dec_onehot;
  logic                            dec_drop;

  arbiter_1_to_n_response_decoder #(
    .NUM_MEMORY_REQUESTOR(NUM_MEMORY_REQUESTOR),
    .ID_WIDTH            (ID_WIDTH)
  ) u_decoder (
    .valid_i   (s1_valid_q),
    .route_id_i(get_response_route_id(s1_payload_q)),
    .cmd_i     (s1_payload_q.meta.cmd),
    .full_i    (eff_full),
    .onehot_o  (dec_onehot),
    .drop_o    (dec_drop)
  );

  for (genvar g = 0; g < NUM_MEMORY_REQUESTOR; g++) begin : g_fifo
    assign fifo_rd_en[g] = ~fifo_empty[g] & rd_en_q[g];
    xpm_fifo_sync_wrapper #(
      .FIFO_WRITE_DEPTH(FIFO_RESPONSE_DEPTH),
      .DATA_WIDTH      (PW),
      .PROG_FULL_THRESH(PROG_THRESH),
      .RST_BUSY_CYCLES (3)
    ) u_fifo (
      .clk_i        (ap_clk),
      .rst_i        (fifo_areset_q),
      .din_i        (s2_payload_q),
      .wr_en_i      (s2_onehot_q[g]),
      .rd_en_i      (fifo_rd_en[g]),
      .dout_o       (fifo_dout[g]),
      .valid_o      (fifo_valid[g]),
      .full_o       (fifo_full[g]),
      .almost_full_o(fifo_afull[g]),
      .empty_o      (fifo_empty[g]),
      .prog_full_o  (fifo_pf[g]),
      .wr_rst_busy_o(fifo_wbusy[g]),
      .rd_rst_busy_o(fifo_rbusy[g])
    );
  end

  always_comb begin
    s1_valid_d  = response_in.valid & ~setup_q;
    rd_en_d     = '0;
    out_valid_d = fifo_valid;
    for (int i = 0; i < NUM_MEMORY_REQUESTOR; i++) begin
      rd_en_d[i] = fifo_response_signals_in[i].rd_en;
    end
    // The write sitting in stage 2 has not reached the FIFO count yet.
    eff_full     = fifo_full | (s2_onehot_q & fifo_afull);
    s2_onehot_d  = dec_onehot;
    drop_count_d = (dec_drop && (drop_count_q != 32'hFFFF_FFFF)) ? drop_count_q + 32'd1
                                                                 : drop_count_q;
    setup_d              = |(fifo_wbusy | fifo_rbusy);
    ready_d              = ~fifo_pf;
    status_d.full        = |fifo_full;
    status_d.empty       = |fifo_empty;
    status_d.prog_full   = |fifo_pf;
    status_d.wr_rst_busy = |fifo_wbusy;
    status_d.rd_rst_busy = |fifo_rbusy;
  end

  always_ff @(posedge ap_clk) begin
    control_areset_q <= areset;
    fifo_areset_q    <= areset;
    if (control_areset_q) begin
      s1_valid_q   <= 1'b0;
      rd_en_q      <= '0;
      s2_onehot_q  <= '0;
      drop_count_q <= '0;
      setup_q      <= 1'b1;
      ready_q      <= '0;
      status_q     <= '0;
      out_valid_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      rd_en_q      <= rd_en_d;
      s2_onehot_q  <= s2_onehot_d;
      drop_count_q <= drop_count_d;
      setup_q      <= setup_d;
      ready_q      <= ready_d;
      status_q     <= status_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    s1_payload_q  <= response_in.payload;
    s2_payload_q  <= s1_payload_q;
    out_payload_q <= fifo_dout;
  end

  always_comb begin
    for (int i = 0; i < NUM_MEMORY_REQUESTOR; i++) begin
      response_out[i].valid   = out_valid_q[i];
      response_out[i].payload = out_payload_q[i];
    end
  end

  assign fifo_response_signals_out = status_q;
  assign response_ready_out        = ready_q;
  assign drop_count                = drop_count_q;
  assign fifo_setup_signal         = setup_q;

endmodule

// File: tb/tb_arbiter_1_to_n_response.sv
// Randomized and directed checks of the 1-to-N response router against a
// queue-based routing model.
module tb_arbiter_1_to_n_response;
  import arbiter_1_to_n_response_pkg::*;

  localparam int unsigned N      = 2;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 12;

  logic                              clk = 1'b0;
  logic                              areset;
  MemoryPacket                       response_in;
  FIFOStateSignalsInput [N-1:0]      sig_in;
  FIFOStateSignalsOutput             sig_out;
  MemoryPacket [N-1:0]               response_out;
  logic [N-1:0]                      ready;
  logic [31:0]                       drop_count;
  logic                              setup;

  always #5 clk = ~clk;

  arbiter_1_to_n_response #(
    .NUM_MEMORY_REQUESTOR(N),
    .FIFO_RESPONSE_DEPTH (DEPTH),
    .PROG_THRESH         (THRESH)
  ) dut (
    .ap_clk                   (clk),
    .areset                   (areset),
    .response_in              (response_in),
    .fifo_response_signals_in (sig_in),
    .fifo_response_signals_out(sig_out),
    .response_out             (response_out),
    .response_ready_out       (ready),
    .drop_count               (drop_count),
    .fifo_setup_signal        (setup)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_drops = 0;
  int rx_cnt [N];
  MemoryPacketPayload exp_q0[$];
  MemoryPacketPayload exp_q1[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic MemoryPacketPayload mk(input int id, input CommandType cmd, input int tag);
    MemoryPacketPayload p;
    p.meta.route.from.id_module = 8'(id);
    p.meta.route.to.id_module   = 8'hA5;
    p.meta.cmd                  = cmd;
    p.data                      = {16'(tag), 16'($urandom)};
    return p;
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Model: deliverable iff a response to an existing requestor whose FIFO has room.
  task automatic send(input int id, input CommandType cmd, input int tag);
    MemoryPacketPayload p = mk(id, cmd, tag);
    response_in.valid   = 1'b1;
    response_in.payload = p;
    if (cmd == CMD_MEM_RESPONSE && id < int'(N) && qsize(id) < int'(DEPTH)) begin
      if (id == 0) exp_q0.push_back(p);
      else         exp_q1.push_back(p);
    end else begin
      model_drops++;
    end
    @(posedge clk); #1;
    response_in.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_setup();
    for (int c = 0; c < 64 && setup; c++) idle(1);
    check_eq("setup_done", 64'(setup), 64'd0);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (response_out[i].valid) begin
        rx_cnt[i]++;
        if (qsize(i) == 0) begin
          check_eq($sformatf("rx%0d_unexpected", i), 64'(response_out[i].valid), 64'd0);
        end else if (i == 0) begin
          check_eq("rx0_payload", 64'(response_out[0].payload), 64'(exp_q0.pop_front()));
        end else begin
          check_eq("rx1_payload", 64'(response_out[1].payload), 64'(exp_q1.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    MemoryPacketPayload p;
    int b0, b1;
    logic pf_seen;
    rx_cnt[0] = 0;
    rx_cnt[1] = 0;
    response_in = '0;
    sig_in      = '0;
    areset      = 1'b1;
    idle(3);
    check_eq("rst_setup", 64'(setup), 64'd1);
    check_eq("rst_drop", 64'(drop_count), 64'd0);
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_status", 64'(sig_out), 64'd0);
    check_eq("rst_valid", 64'({response_out[1].valid, response_out[0].valid}), 64'd0);
    areset = 1'b0;
    wait_setup();
    idle(2);
    check_eq("ready_after_rst", 64'(ready), 64'd3);

    // Latency: input at cycle 0, output exactly at cycle 5.
    sig_in = '1;
    idle(2);
    p = mk(1, CMD_MEM_RESPONSE, 100);
    response_in.valid   = 1'b1;
    response_in.payload = p;
    exp_q1.push_back(p);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) response_in.valid = 1'b0;
      check_eq($sformatf("lat_out1_c%0d", k), 64'(response_out[1].valid), 64'(k == 5));
      check_eq($sformatf("lat_out0_c%0d", k), 64'(response_out[0].valid), 64'd0);
    end
    idle(2);
    check_eq("lat_drops", 64'(drop_count), 64'd0);

    // Interleave across requestors.
    b0 = rx_cnt[0]; b1 = rx_cnt[1];
    for (int t = 0; t < 8; t++) send(t % 2, CMD_MEM_RESPONSE, t);
    idle(12);
    check_eq("ilv_rx0", 64'(rx_cnt[0] - b0), 64'd4);
    check_eq("ilv_rx1", 64'(rx_cnt[1] - b1), 64'd4);
    check_eq("ilv_drops", 64'(drop_count), 64'(model_drops));

    // Unroutable id and non-response command.
    b0 = rx_cnt[0]; b1 = rx_cnt[1];
    send(3, CMD_MEM_RESPONSE, 200);
    send(0, CMD_MEM_READ, 201);
    idle(10);
    check_eq("bad_drops", 64'(drop_count), 64'(model_drops));
    check_eq("bad_rx", 64'((rx_cnt[0] - b0) + (rx_cnt[1] - b1)), 64'd0);

    // Random traffic, both requestors draining.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else send(int'($urandom_range(3)), CommandType'($urandom_range(3)), 1000 + i);
    end
    idle(20);
    check_eq("rnd_q_left", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    check_eq("rnd_drops", 64'(drop_count), 64'(model_drops));

    // Backpressure and overflow on requestor 0.
    sig_in[0].rd_en = 1'b0;
    idle(2);
    for (int t = 0; t < 11; t++) send(0, CMD_MEM_RESPONSE, 300 + t);
    idle(6);
    check_eq("pf_below", 64'(sig_out.prog_full), 64'd0);
    check_eq("ready_below", 64'(ready[0]), 64'd1);
    for (int t = 11; t < 20; t++) send(0, CMD_MEM_RESPONSE, 300 + t);
    idle(6);
    check_eq("pf_above", 64'(sig_out.prog_full), 64'd1);
    check_eq("ready_above", 64'(ready[0]), 64'd0);
    check_eq("ready1_above", 64'(ready[1]), 64'd1);
    check_eq("ovf_drops", 64'(drop_count), 64'(model_drops));
    b0 = rx_cnt[0];
    sig_in[0].rd_en = 1'b1;
    idle(30);
    check_eq("ovf_drain", 64'(rx_cnt[0] - b0), 64'(DEPTH));
    check_eq("pf_drained", 64'(sig_out.prog_full), 64'd0);

    // Concurrent push/pop on requestor 1.
    b1 = rx_cnt[1];
    pf_seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      send(1, CMD_MEM_RESPONSE, 500 + t);
      pf_seen |= sig_out.prog_full;
    end
    idle(10);
    check_eq("cc_rx1", 64'(rx_cnt[1] - b1), 64'd100);
    check_eq("cc_pf_seen", 64'(pf_seen), 64'd0);

    // Reset while packets are queued.
    sig_in = '0;
    idle(2);
    for (int t = 0; t < 5; t++) send(t % 2, CMD_MEM_RESPONSE, 700 + t);
    idle(6);
    areset = 1'b1;
    idle(2);
    check_eq("mrst_setup", 64'(setup), 64'd1);
    check_eq("mrst_drop", 64'(drop_count), 64'd0);
    check_eq("mrst_ready", 64'(ready), 64'd0);
    check_eq("mrst_status", 64'(sig_out), 64'd0);
    check_eq("mrst_valid", 64'({response_out[1].valid, response_out[0].valid}), 64'd0);
    exp_q0.delete();
    exp_q1.delete();
    model_drops = 0;
    b0 = rx_cnt[0]; b1 = rx_cnt[1];
    areset = 1'b0;
    sig_in = '1;
    // Unroutable packet during setup must be ignored, not counted.
    response_in.valid   = 1'b1;
    response_in.payload = mk(3, CMD_MEM_RESPONSE, 800);
    idle(1);
    response_in.valid = 1'b0;
    wait_setup();
    idle(10);
    check_eq("post_rst_drop", 64'(drop_count), 64'd0);
    check_eq("post_rst_rx", 64'((rx_cnt[0] - b0) + (rx_cnt[1] - b1)), 64'd0);
    check_eq("post_rst_ready", 64'(ready), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_1_to_n_response.md
Name: arbiter_1_to_N_response

Overview:
- Downstream companion of the N-to-1 request arbiter. Takes the single memory-response stream coming back from the cache/memory channel and routes each packet to its originating requestor.
- Routing uses the packet's route id. Each requestor has its own FIFO with independent pop control.
- Aggregated prog_full backpressure goes upstream. A drop counter records unroutable, non-response or overflowing packets.

Parameters:
- NUM_MEMORY_REQUESTOR, 2, number of destination requestors (1..16).
- ID_WIDTH, $clog2(NUM_MEMORY_REQUESTOR) min 1, width of route id field used for decode.
- FIFO_RESPONSE_DEPTH, 16, per-requestor FIFO depth (power of 2).
- PROG_THRESH, 12, per-requestor prog_full threshold.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  reset; one clock, synchronous, active-high.
- response_in  in  MemoryPacket  incoming response, qualified by .valid.
- fifo_response_signals_in  in  FIFOStateSignalsInput[NUM_MEMORY_REQUESTOR]  per-requestor pop request (.rd_en).
- fifo_response_signals_out  out  FIFOStateSignalsOutput  aggregated status: prog_full = OR of all per-requestor prog_full; other fields OR-reduced.
- response_out  out  MemoryPacket[NUM_MEMORY_REQUESTOR]  routed responses, one per requestor.
- response_ready_out  out  NUM_MEMORY_REQUESTOR  per-requestor ~prog_full, registered.
- drop_count  out  32  saturating count of dropped packets.
- fifo_setup_signal  out  1  high while any FIFO is in reset (wr_rst_busy | rd_rst_busy).

Behaviour:
- Reset handling: areset is registered into local copies (control, fifo) one cycle before use.
- Reset values (cycle after registered reset asserts):
  - response_out[i].valid = 0
  - fifo_response_signals_out = 0
  - response_ready_out = 0
  - drop_count = 0
  - fifo_setup_signal = 1
- Payload registers are not reset.
- Stage 1: response_in is registered (valid reset, payload not reset). fifo_response_signals_in[i].rd_en is also registered.
- Stage 2, decode:
  - id = payload.meta.route.from.id_module[ID_WIDTH-1:0].
  - Accept when valid & cmd==CMD_MEM_RESPONSE & id<NUM_MEMORY_REQUESTOR & ~full[id].
  - Produce a one-hot write vector plus the payload, registered.
- Drop: any valid packet failing a condition above is dropped and increments drop_count by 1. drop_count saturates at 32'hFFFF_FFFF. At most one increment per cycle.
- Push: wr_en[i] = onehot_reg[i]. At most one FIFO is written per cycle.
- FIFOs: one xpm_fifo_sync_wrapper per requestor, WRITE/READ width = $bits(MemoryPacketPayload), standard read mode, 1-cycle read latency.
- Pop: rd_en[i] = ~empty[i] & rd_en_reg[i]. FIFO valid[i] drives response_out_int[i].valid.
- Output: response_out[i] is registered (valid reset, payload not).
- Latency: response_in valid at cycle 0 with target rd_en held high gives response_out[id].valid at cycle 5. Throughput is 1 packet/cycle total.
- Ordering: per-requestor FIFO order is preserved. There is no ordering guarantee across requestors.
- Empty FIFO: rd_en held high produces no valid and leaves FIFO state unchanged.
- Full / prog_full:
  - prog_full[i] deasserts response_ready_out[i] one cycle later and raises fifo_response_signals_out.prog_full.
  - Upstream must stop within PROG_THRESH slack. Writes arriving while full[i] are dropped and counted, never overwrite.
- Simultaneous push and pop on the same FIFO: both occur, occupancy unchanged.
- Reset mid-operation: all FIFOs flush, and in-flight stage-1/2 valids clear. fifo_setup_signal stays high until every wr_rst_busy/rd_rst_busy clears. Packets presented during setup are ignored and not counted.

Decomposition:
- Shared global package additions:
  - RESPONSE_ROUTE_ID_MAX constant.
  - Helper function get_response_route_id(MemoryPacketPayload) returning the id field.
- CMD_MEM_RESPONSE, MemoryPacket, FIFOStateSignals* types are already shared.
- Reuse xpm_fifo_sync_wrapper per requestor, instantiated in a generate loop.
- Optional sub-module: response_route_decoder. It is combinational: id/cmd/full in, one-hot + drop out, which keeps the decode independently testable.

Test Plan:
- Latency: after reset completes (fifo_setup_signal=0), one CMD_MEM_RESPONSE with id=1 and rd_en[1]=1 at cycle 0 -> response_out[1].valid exactly at cycle 5 with identical payload; response_out[0].valid stays 0; drop_count=0.
- Interleave: 8 back-to-back packets alternating id 0/1, tagged 0..7, both rd_en high -> requestor 0 receives tags 0,2,4,6 and requestor 1 receives tags 1,3,5,7, in order, no drops.
- Unroutable / non-response (N=2): packet with id=3 and a packet with cmd≠CMD_MEM_RESPONSE -> neither appears on any output; drop_count=2.
- Backpressure and overflow: rd_en[0]=0, stream 20 packets to id 0 (depth 16, thresh 12):
  - prog_full rises and response_ready_out[0]=0 after occupancy reaches 12;
  - 16 packets are stored and 4 dropped, so drop_count=4;
  - then with rd_en[0]=1, exactly 16 packets drain in order.
- Reset mid-stream: assert areset for 2 cycles while 5 packets are queued -> all outputs take their reset values; fifo_setup_signal=1 until FIFO reset busy clears; afterwards no stale packet is emitted and drop_count=0.
- Concurrent push/pop: hold rd_en[1]=1 with continuous id=1 traffic for 100 cycles -> 100 outputs, occupancy ≤1, prog_full never asserted.
